// File: rtl/uart_pkg.sv
// Shared state encoding and parity-mode constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic bit has_parity(input int mode);
    return mode != PAR_NONE;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and restarts at
// every bit boundary; pre_tick flags the cycle before the boundary.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = en && (cnt_q == LAST);
  assign pre_tick = en && (cnt_q == PRE_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || bit_tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with registered outputs.
// Optional line-break input tx_break is compiled in with UART_TX_BREAK_EN.
//
//   state     | meaning
//   ST_IDLE   | line high (low during break), tx_ready high unless break
//   ST_START  | start bit, line low
//   ST_DATA   | data bits, LSB first, from the shift register
//   ST_PARITY | parity bit (skipped when PARITY_MODE is none)
//   ST_STOP   | STOP_BITS stop bits, line high; tx_done on final cycle
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 tx_ready,
  output logic                 out_tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);
  localparam bit            HAS_PAR = has_parity(PARITY_MODE);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 out_tx_q, out_tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 brk_d;
  logic                 handshake;
  logic                 baud_en;
  logic                 bit_tick;
  logic                 pre_tick;

  assign handshake = tx_valid && tx_ready_q;
  assign baud_en   = (state_q != ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (baud_en),
    .clr     (!baud_en),
    .bit_tick(bit_tick),
    .pre_tick(pre_tick)
  );

  // A break request only takes hold once the line is (or is about to be) idle,
  // so a frame in flight always completes first.
`ifdef UART_TX_BREAK_EN
  assign brk_d = tx_break && (state_d == ST_IDLE);
`else
  assign brk_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      out_tx_q   <= 1'b1;
      tx_ready_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      out_tx_q   <= out_tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d    = ST_START;
          shift_d    = tx_data;
          parity_d   = (^tx_data) ^ (PARITY_MODE == PAR_ODD);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d    = ST_IDLE;
            stop_cnt_d = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so the registered copies line
  // up with the state they describe; tx_done is set one cycle early to land on
  // the final stop-bit cycle.
  always_comb begin
    out_tx_d   = 1'b1;
    tx_ready_d = 1'b0;
    tx_busy_d  = (state_d != ST_IDLE);
    tx_done_d  = (state_q == ST_STOP) && (stop_cnt_q == LAST_STOP) && pre_tick;
    case (state_d)
      ST_IDLE: begin
        out_tx_d   = !brk_d;
        tx_ready_d = !brk_d;
      end
      ST_START:  out_tx_d = 1'b0;
      ST_DATA:   out_tx_d = shift_d[0];
      ST_PARITY: out_tx_d = parity_d;
      default:   out_tx_d = 1'b1;
    endcase
  end

  assign tx_ready = tx_ready_q;
  assign out_tx   = out_tx_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule
